// File: rtl/motor_ramp_ctrl.sv
// Rate-limited speed sequencer for the dual H-bridge driver.
// Per-channel ramp, reversal dwell, command timeout and estop.
module motor_ramp_chan #(
  parameter int DWELL_TICKS = 50
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              estop,
  input  logic [3:0]        step,
  input  logic signed [7:0] tgt,
  output logic signed [7:0] cur,
  output logic              dwelling
);

  localparam int CW = $clog2(DWELL_TICKS + 1);

  typedef enum logic {
    TRACK,
    DWELL
  } state_t;

  state_t            state_q, state_n;
  logic [CW-1:0]     cnt_q, cnt_n;
  logic              dir_q, dir_n;
  logic signed [7:0] cur_n;
  logic signed [8:0] c9, t9, s9, up, dn, mv;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TRACK;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      cur     <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      dir_q   <= dir_n;
      cur     <= cur_n;
    end
  end

  always_comb begin
    c9      = {cur[7], cur};
    t9      = {tgt[7], tgt};
    s9      = {5'b0, step};
    up      = c9 + s9;
    dn      = c9 - s9;
    mv      = c9;
    state_n = state_q;
    cnt_n   = cnt_q;
    dir_n   = dir_q;
    cur_n   = cur;
    if (estop) begin
      state_n = TRACK;
      cnt_n   = '0;
      cur_n   = '0;
    end else if (tick) begin
      unique case (state_q)
        TRACK: begin
          if (c9 != t9) begin
            if (!(c9[8] ^ t9[8]) || c9 == 0 || t9 == 0) begin
              if (t9 > c9)
                mv = (step == 0 || up > t9) ? t9 : up;
              else
                mv = (step == 0 || dn < t9) ? t9 : dn;
            end else begin
              // opposite signs: decelerate to zero first
              if (c9 > 0)
                mv = (step == 0 || dn < 0) ? 9'sd0 : dn;
              else
                mv = (step == 0 || up > 0) ? 9'sd0 : up;
              if (mv == 0) begin
                state_n = DWELL;
                cnt_n   = '0;
                dir_n   = c9[8];
              end
            end
            cur_n = 8'(mv);
          end
        end
        DWELL: begin
          cur_n = '0;
          if (t9 == 0 || t9[8] == dir_q) begin
            state_n = TRACK;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_q + CW'(1);
            if (cnt_n == CW'(DWELL_TICKS)) begin
              state_n = TRACK;
              cnt_n   = '0;
            end
          end
        end
      endcase
    end
  end

  assign dwelling = (state_q == DWELL);

endmodule

module motor_ramp_ctrl #(
  parameter int RAMP_DIV      = 16000,
  parameter int DWELL_TICKS   = 50,
  parameter int TIMEOUT_TICKS = 250
) (
  input  logic              clk_16mhz,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic signed [7:0] cmd_speed_a,
  input  logic signed [7:0] cmd_speed_b,
  input  logic [3:0]        cfg_step,
  input  logic              estop,
  output logic signed [7:0] speed_a,
  output logic signed [7:0] speed_b,
  output logic              alive_strobe,
  output logic              busy,
  output logic              timed_out
);

  localparam int DW = $clog2(RAMP_DIV);
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);

  logic [DW-1:0]     tick_cnt;
  logic [TW-1:0]     to_cnt;
  logic              tick;
  logic              accept;
  logic              fire;
  logic signed [7:0] tgt_a, tgt_b;
  logic              dw_a, dw_b;

  function automatic logic signed [7:0] clamp(input logic signed [7:0] v);
    return (v == 8'sh80) ? 8'sh81 : v;
  endfunction

  assign cmd_ready = !estop && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign tick      = (tick_cnt == DW'(RAMP_DIV - 1));
  assign fire      = tick && (to_cnt == TW'(TIMEOUT_TICKS - 1));

  // later assignments take priority: accept beats timeout and estop
  always_ff @(posedge clk_16mhz) begin
    if (rst) begin
      tick_cnt     <= '0;
      to_cnt       <= '0;
      tgt_a        <= '0;
      tgt_b        <= '0;
      alive_strobe <= 1'b0;
      timed_out    <= 1'b0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + DW'(1);
      if (tick && to_cnt != TW'(TIMEOUT_TICKS))
        to_cnt <= to_cnt + TW'(1);
      if (fire) begin
        timed_out <= 1'b1;
        tgt_a     <= '0;
        tgt_b     <= '0;
      end
      if (estop) begin
        tgt_a <= '0;
        tgt_b <= '0;
      end
      if (accept) begin
        tgt_a        <= clamp(cmd_speed_a);
        tgt_b        <= clamp(cmd_speed_b);
        to_cnt       <= '0;
        timed_out    <= 1'b0;
        alive_strobe <= ~alive_strobe;
      end
    end
  end

  motor_ramp_chan #(
    .DWELL_TICKS(DWELL_TICKS)
  ) u_chan_a (
    .clk      (clk_16mhz),
    .rst      (rst),
    .tick     (tick),
    .estop    (estop),
    .step     (cfg_step),
    .tgt      (tgt_a),
    .cur      (speed_a),
    .dwelling (dw_a)
  );

  motor_ramp_chan #(
    .DWELL_TICKS(DWELL_TICKS)
  ) u_chan_b (
    .clk      (clk_16mhz),
    .rst      (rst),
    .tick     (tick),
    .estop    (estop),
    .step     (cfg_step),
    .tgt      (tgt_b),
    .cur      (speed_b),
    .dwelling (dw_b)
  );

  assign busy = (speed_a != tgt_a) || (speed_b != tgt_b) || dw_a || dw_b;

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Bench for motor_ramp_ctrl: per-tick speed scoreboard from a
// vector table, plus estop, timeout and reset sequences.
module tb_motor_ramp_ctrl;

  localparam int RD = 4;

  logic              clk_16mhz = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic signed [7:0] cmd_speed_a;
  logic signed [7:0] cmd_speed_b;
  logic [3:0]        cfg_step;
  logic              estop;
  logic signed [7:0] speed_a;
  logic signed [7:0] speed_b;
  logic              alive_strobe;
  logic              busy;
  logic              timed_out;

  always #5 clk_16mhz = ~clk_16mhz;

  motor_ramp_ctrl #(
    .RAMP_DIV      (RD),
    .DWELL_TICKS   (2),
    .TIMEOUT_TICKS (20)
  ) dut (
    .clk_16mhz    (clk_16mhz),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_speed_a  (cmd_speed_a),
    .cmd_speed_b  (cmd_speed_b),
    .cfg_step     (cfg_step),
    .estop        (estop),
    .speed_a      (speed_a),
    .speed_b      (speed_b),
    .alive_strobe (alive_strobe),
    .busy         (busy),
    .timed_out    (timed_out)
  );

  typedef struct {
    int ea;
    int eb;
    int bz;
  } exp_t;

  typedef struct {
    int send;
    int ca;
    int cb;
    int step;
    int ea;
    int eb;
    int bz;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   tc     = 0;
  int   sends  = 0;
  bit   is_tick;
  event tick_ev;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t mke(input int a, input int b, input int z);
    exp_t e;
    e.ea = a;
    e.eb = b;
    e.bz = z;
    return e;
  endfunction

  function automatic vec_t mkv(input int s, input int a, input int b,
                               input int st, input int ea, input int eb,
                               input int bz);
    vec_t v;
    v.send = s;
    v.ca   = a;
    v.cb   = b;
    v.step = st;
    v.ea   = ea;
    v.eb   = eb;
    v.bz   = bz;
    return v;
  endfunction

  // bench-side tick tracker; scoreboard compares just after each tick edge
  always @(posedge clk_16mhz) begin
    exp_t e;
    is_tick = !rst && tc == RD - 1;
    tc = rst ? 0 : (tc == RD - 1 ? 0 : tc + 1);
    if (is_tick) begin
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("tick_speed_a", int'(speed_a), e.ea);
        chk("tick_speed_b", int'(speed_b), e.eb);
        chk("tick_busy", int'(busy), e.bz);
      end
      ->tick_ev;
    end
  end

  task automatic send(input int a, input int b);
    cmd_speed_a = 8'(a);
    cmd_speed_b = 8'(b);
    cmd_valid   = 1'b1;
    @(posedge clk_16mhz);
    #1;
    cmd_valid = 1'b0;
    sends++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int alive0;
    rst         = 1'b1;
    cmd_valid   = 1'b0;
    cmd_speed_a = '0;
    cmd_speed_b = '0;
    cfg_step    = 4'd5;
    estop       = 1'b0;

    vecs.push_back(mkv(1, 20, -13, 5, 5, -5, 1));
    vecs.push_back(mkv(0, 0, 0, 5, 10, -10, 1));
    vecs.push_back(mkv(0, 0, 0, 5, 15, -13, 1));
    vecs.push_back(mkv(0, 0, 0, 5, 20, -13, 0));
    vecs.push_back(mkv(1, 12, -13, 5, 15, -13, 1));
    vecs.push_back(mkv(0, 0, 0, 5, 12, -13, 0));
    vecs.push_back(mkv(1, -7, -13, 5, 7, -13, 1));
    vecs.push_back(mkv(0, 0, 0, 5, 2, -13, 1));
    vecs.push_back(mkv(0, 0, 0, 5, 0, -13, 1));
    vecs.push_back(mkv(0, 0, 0, 5, 0, -13, 1));
    vecs.push_back(mkv(0, 0, 0, 5, 0, -13, 1));
    vecs.push_back(mkv(0, 0, 0, 5, -5, -13, 1));
    vecs.push_back(mkv(0, 0, 0, 5, -7, -13, 0));
    vecs.push_back(mkv(1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(1, 100, 0, 0, 100, 0, 0));
    vecs.push_back(mkv(1, -100, 0, 0, 0, 0, 1));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mkv(0, 0, 0, 0, -100, 0, 0));
    vecs.push_back(mkv(1, 0, 127, 5, -95, 5, 1));
    vecs.push_back(mkv(0, 0, 0, 3, -92, 8, 1));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 127, 0));
    vecs.push_back(mkv(1, 50, 127, 0, 50, 127, 0));
    vecs.push_back(mkv(1, -50, 127, 0, 0, 127, 1));
    vecs.push_back(mkv(1, 30, 127, 0, 0, 127, 1));
    vecs.push_back(mkv(0, 0, 0, 0, 30, 127, 0));
    vecs.push_back(mkv(1, -128, -128, 0, 0, 0, 1));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mkv(0, 0, 0, 0, -127, -127, 0));

    repeat (3) @(posedge clk_16mhz);
    #1;
    chk("rst_speed_a", int'(speed_a), 0);
    chk("rst_speed_b", int'(speed_b), 0);
    chk("rst_alive", int'(alive_strobe), 0);
    chk("rst_timed_out", int'(timed_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(cmd_ready), 0);
    @(negedge clk_16mhz);
    rst = 1'b0;
    #1;
    chk("ready_idle", int'(cmd_ready), 1);
    @(tick_ev);

    for (int i = 0; i < vecs.size(); i++) begin
      cfg_step = 4'(vecs[i].step);
      if (vecs[i].send != 0)
        send(vecs[i].ca, vecs[i].cb);
      if (i == 0)
        chk("alive_first", int'(alive_strobe), 1);
      sb.push_back(mke(vecs[i].ea, vecs[i].eb, vecs[i].bz));
      @(tick_ev);
      chk("sb_drained", sb.size(), 0);
    end
    chk("alive_parity", int'(alive_strobe), sends % 2);

    // estop from a running speed
    cfg_step = 4'd0;
    send(0, 0);
    sb.push_back(mke(0, 0, 0));
    @(tick_ev);
    send(60, 0);
    sb.push_back(mke(60, 0, 0));
    @(tick_ev);
    alive0 = int'(alive_strobe);
    estop  = 1'b1;
    #1;
    chk("estop_ready", int'(cmd_ready), 0);
    @(posedge clk_16mhz);
    #1;
    chk("estop_speed_a", int'(speed_a), 0);
    chk("estop_busy", int'(busy), 0);
    cmd_speed_a = 8'sd40;
    cmd_valid   = 1'b1;
    @(tick_ev);
    @(tick_ev);
    chk("estop_hold_a", int'(speed_a), 0);
    chk("estop_alive", int'(alive_strobe), alive0);
    cmd_valid = 1'b0;
    estop     = 1'b0;
    cfg_step  = 4'd5;
    send(40, 0);
    sb.push_back(mke(5, 0, 1));
    @(tick_ev);

    // command timeout
    cfg_step = 4'd0;
    send(30, 0);
    sb.push_back(mke(30, 0, 0));
    @(tick_ev);
    cfg_step = 4'd5;
    for (int k = 2; k <= 19; k++) @(tick_ev);
    chk("to_early", int'(timed_out), 0);
    @(tick_ev);
    chk("to_fired", int'(timed_out), 1);
    chk("to_hold_a", int'(speed_a), 30);
    for (int k = 25; k >= 0; k -= 5) begin
      sb.push_back(mke(k, 0, k != 0 ? 1 : 0));
      @(tick_ev);
    end
    send(10, 0);
    chk("to_cleared", int'(timed_out), 0);
    sb.push_back(mke(5, 0, 1));
    @(tick_ev);
    sb.push_back(mke(10, 0, 0));
    @(tick_ev);

    // accept lands on the timeout tick
    cfg_step = 4'd0;
    for (int k = 3; k <= 19; k++) @(tick_ev);
    alive0 = int'(alive_strobe);
    repeat (3) @(posedge clk_16mhz);
    #1;
    cmd_speed_a = 8'sd20;
    cmd_speed_b = 8'sd0;
    cmd_valid   = 1'b1;
    @(posedge clk_16mhz);
    #1;
    cmd_valid = 1'b0;
    chk("race_timed_out", int'(timed_out), 0);
    chk("race_alive", int'(alive_strobe), 1 - alive0);
    chk("race_old_a", int'(speed_a), 10);
    sb.push_back(mke(20, 0, 0));
    @(tick_ev);
    chk("race_timed_out2", int'(timed_out), 0);

    // reset mid-ramp overrides estop and cmd_valid
    cfg_step = 4'd5;
    send(100, 100);
    sb.push_back(mke(25, 5, 1));
    @(tick_ev);
    @(negedge clk_16mhz);
    rst         = 1'b1;
    estop       = 1'b1;
    cmd_valid   = 1'b1;
    cmd_speed_a = 8'sd50;
    @(posedge clk_16mhz);
    #1;
    chk("mrst_speed_a", int'(speed_a), 0);
    chk("mrst_speed_b", int'(speed_b), 0);
    chk("mrst_alive", int'(alive_strobe), 0);
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_ready", int'(cmd_ready), 0);
    @(negedge clk_16mhz);
    rst       = 1'b0;
    estop     = 1'b0;
    cmd_valid = 1'b0;
    @(tick_ev);
    send(-20, 0);
    sb.push_back(mke(-5, 0, 1));
    @(tick_ev);
    chk("final_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
